// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared condition-code, NZCV index and FlagW definitions
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit 1 selects the N,Z half; bit 0 selects the C,V half.
    typedef struct packed {
        logic nz;
        logic cv;
    } flagw_t;

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// ============================================================================
// cond_check : combinational evaluation of a 4-bit condition against NZCV
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = Flags[FLAG_N];
    assign w_z = Flags[FLAG_Z];
    assign w_c = Flags[FLAG_C];
    assign w_v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b1;
        case (Cond)
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = (w_n == w_v);
            COND_LT: CondEx = (w_n != w_v);
            COND_GT: CondEx = ~w_z & (w_n == w_v);
            COND_LE: CondEx = w_z | (w_n != w_v);
            // NV is executed unconditionally, same as AL.
            default: CondEx = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
// cond_logic : NZCV flag register, condition check and commit strobe gating
// Revision: 1.0
// ============================================================================
`default_nettype none

module cond_logic
    import cpu_pkg::*;
#(
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       flush,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic [3:0] r_flags;
    logic       w_go;
    flagw_t     w_flagw;

    assign w_flagw = flagw_t'(FlagW);

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (r_flags),
        .CondEx (CondEx)
    );

    assign w_go = CondEx & en & ~flush & ~reset;

    assign PCSrc    = PCS & w_go;
    assign RegWrite = RegW & ~NoWrite & w_go;
    assign MemWrite = MemW & w_go;
    assign Flags    = r_flags;

    // Every flag write is qualified by w_go so stalled or killed slots cannot disturb NZCV.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= RST_FLAGS;
        end else if (w_go) begin
            if (w_flagw.nz) begin
                r_flags[FLAG_N] <= ALUFlags[FLAG_N];
                r_flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (w_flagw.cv) begin
                r_flags[FLAG_C] <= ALUFlags[FLAG_C];
                r_flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cond_logic.sv
// ============================================================================
// tb_cond_logic : directed and randomized checks of cond_logic against a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cond_logic;

    localparam logic [3:0] RST_FLAGS = 4'b0000;

    logic       clk = 1'b0;
    logic       reset, en, flush, PCS, RegW, MemW, NoWrite;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags = 4'b0000;
    bit         m_valid = 1'b0;

    cond_logic #(.RST_FLAGS(RST_FLAGS)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    always #5 clk = ~clk;

    // Architectural rule: even codes test a base predicate, odd codes its inverse; 111x always passes.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic logic model_go();
        return model_pass(Cond, m_flags) && (en === 1'b1) && (flush === 1'b0) && (reset === 1'b0);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] mask;
        if (reset === 1'b1) begin
            m_flags <= RST_FLAGS;
            m_valid <= 1'b1;
        end else if (m_valid && model_go()) begin
            mask = {{2{FlagW[1]}}, {2{FlagW[0]}}};
            m_flags <= (m_flags & ~mask) | (ALUFlags & mask);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic go;
            go = model_go();
            chk("model_flags",  Flags,         m_flags);
            chk("model_condex", {3'b0, CondEx}, {3'b0, model_pass(Cond, m_flags)});
            chk("model_pcsrc",  {3'b0, PCSrc},  {3'b0, PCS & go});
            chk("model_regw",   {3'b0, RegWrite}, {3'b0, RegW & ~NoWrite & go});
            chk("model_memw",   {3'b0, MemWrite}, {3'b0, MemW & go});
        end
    end

    task automatic apply(input logic r, input logic e, input logic fl, input logic [3:0] c,
                         input logic [3:0] alu, input logic [1:0] fw, input logic pcs,
                         input logic rw, input logic mw, input logic nw);
        reset = r; en = e; flush = fl; Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        apply(0, 1, 0, 4'hE, f, 2'b11, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        // Reset: strobes forced low while reset is high.
        apply(1, 1, 0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0);
        chk("rst_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
        chk("rst_flags", Flags, 4'b0000);
        chk("post_rst_regwrite", {3'b0, RegWrite}, 4'b0001);
        tick();

        // CMP setting Z, then BEQ.
        apply(0, 1, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
        chk("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
        tick();
        apply(0, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("cmp_flags", Flags, 4'b0100);
        chk("beq_taken", {3'b0, PCSrc}, 4'b0001);
        tick();
        apply(0, 1, 0, 4'hE, 4'b0000, 2'b11, 0, 1, 0, 1);
        tick();
        apply(0, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("beq_not_taken", {3'b0, PCSrc}, 4'b0000);
        tick();

        // Partial flag writes.
        set_flags(4'b1111);
        apply(0, 1, 0, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
        tick();
        apply(0, 1, 0, 4'hE, 4'b0000, 2'b01, 0, 0, 0, 0);
        chk("partial_nz", Flags, 4'b0011);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("partial_cv", Flags, 4'b0000);
        tick();

        // Signed compares.
        set_flags(4'b1001);
        apply(0, 1, 0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("gt_nv_eq", {3'b0, CondEx}, 4'b0001);
        apply(0, 1, 0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("lt_nv_eq", {3'b0, CondEx}, 4'b0000);
        tick();
        set_flags(4'b1000);
        apply(0, 1, 0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("gt_nv_ne", {3'b0, CondEx}, 4'b0000);
        apply(0, 1, 0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("lt_nv_ne", {3'b0, CondEx}, 4'b0001);
        apply(0, 1, 0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("nv_as_al", {3'b0, CondEx}, 4'b0001);
        tick();

        // Failed condition blocks both strobes and flag writes.
        set_flags(4'b0000);
        apply(0, 1, 0, 4'h0, 4'b1111, 2'b11, 0, 0, 1, 0);
        chk("fail_memwrite", {3'b0, MemWrite}, 4'b0000);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("fail_flags", Flags, 4'b0000);
        tick();

        // Stall, flush, both, then release.
        apply(0, 0, 0, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        chk("stall_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
        tick();
        apply(0, 1, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        chk("stall_flags", Flags, 4'b0000);
        chk("flush_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0000);
        tick();
        apply(0, 0, 1, 4'hE, 4'b1010, 2'b11, 1, 1, 1, 0);
        chk("flush_flags", Flags, 4'b0000);
        tick();
        apply(0, 1, 0, 4'hE, 4'b1010, 2'b11, 0, 0, 0, 0);
        chk("both_flags", Flags, 4'b0000);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("release_flags", Flags, 4'b1010);
        tick();

        // X on data inputs while stalled must not reach the flags.
        apply(0, 0, 0, 4'hE, 4'bxxxx, 2'bxx, 0, 0, 0, 0);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("x_stall_flags", Flags, 4'b1010);
        tick();

        // Reset during a stall wins.
        apply(1, 0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        tick();
        apply(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        chk("rst_mid_stall", Flags, RST_FLAGS);
        tick();

        // Randomized traffic, checked every cycle by the model compare process.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
